div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Multi-cycle radix-2 restoring divider that serves the EX stage for DIV/DIVU.
- It is the requesting end of the pipeline stall protocol. While a division is in flight it raises stallreq_o, which feeds the stall controller's EX stall-request input.
- The stall controller then freezes PC, IF/ID, ID/EX and EX (stall = 6'b001111), so EX operands and start_i stay stable.
- The result is delivered as {remainder, quotient} for the HI/LO write path.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH; result width is 2*WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high (`RstEnable = 1'b1)
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  EX requests a division; held high until ready_o is seen
annul_i  input  1  cancel in-flight division (branch-delay flush / exception)
result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
ready_o  output  1  result_o valid
stallreq_o  output  1  stall request to the stall controller (`Stop / `NoStop)

Behaviour:
- Reset: state = FREE, result_o = 0, ready_o = 0, cnt = 0, stallreq_o = `NoStop.
  - Reset dominates all inputs and any state, including mid-operation.
- stallreq_o (combinational) = !rst & start_i & !ready_o.
  - High from the first start_i cycle up to, but not including, the cycle ready_o = 1.
- FREE:
  - Condition to leave: start_i=1 and annul_i=0.
  - If opdata2_i == 0, go to BYZERO.
  - Otherwise go to ON, with cnt = 0 and divisor = |opdata2_i|.
  - Working register (2*WIDTH+1 bits) = {WIDTH'b0, |opdata1_i|, 1'b0}.
  - Absolute value is taken only when signed_div_i=1 and the sign bit is set; else the operand is used raw.
  - Operand signs and signed_div_i are latched at this point.
- ON:
  - annul_i=1: return to FREE; ready_o stays 0 and the result is discarded.
  - cnt < WIDTH: diff = work[2W:W] - {1'b0, divisor}.
    - diff negative: work = {work[2W-1:0], 1'b0}.
    - diff non-negative: work = {diff[W-1:0], work[W-1:0], 1'b1}.
    - Then cnt++.
  - cnt == WIDTH: sign-correct and go to END.
    - Quotient = work[W-1:0]; negated if signed and the operand signs differ.
    - Remainder = work[2W:W+1]; negated if signed and the dividend is negative.
    - Register result_o and set ready_o = 1.
- BYZERO: result_o = 0, go to END, ready_o = 1.
- END:
  - start_i=0: go to FREE, ready_o = 0; result_o holds its value until the next load.
  - start_i=1: hold END and ready_o = 1. A back-to-back division must drop start_i for at least one cycle.
- Latency:
  - Non-zero divisor: start_i sampled at edge 1; ready_o high after edge 34 (WIDTH + 2).
  - Zero divisor: ready_o high after edge 2.
- Signed overflow: -2^31 / -1 gives quotient 0x80000000 and remainder 0 (two's-complement wrap). No trap.
- annul_i in FREE, BYZERO or END has no effect except blocking a new start in FREE.
- start_i dropping in ON without annul_i is illegal. The bench asserts it never happens; the RTL continues to END.

Decomposition:
- Shared defines.h additions:
  - 2-bit state codes `DivFree, `DivByZero, `DivOn, `DivEnd.
  - `DivResultReady / `DivResultNotReady.
  - `DivStart / `DivStop.
  - The existing `Stop / `NoStop and `RstEnable are reused.
- Single module. The subtract/shift step is a few lines and stays inline; no sub-module.

Test Plan:
- Unsigned 100 / 7 (signed_div_i=0), start_i held -> stallreq_o=1 for 34 cycles; then ready_o=1, result_o = {32'd2, 32'd14}, stallreq_o=0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF after 34 cycles.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000; unsigned same operands -> quotient 0, remainder 0x80000000.
- Divide by zero, 123 / 0 -> ready_o=1 after 2 edges, result_o = 0, stallreq_o high for exactly 2 cycles.
- annul_i pulsed at cycle 10 of ON -> state FREE next edge, ready_o never asserts. A following 9 / 3 (start_i re-raised) completes with quotient 3, remainder 0 after 34 cycles.
- rst asserted at cycle 20 of ON -> next edge: ready_o=0, result_o=0, FREE, stallreq_o=0. Then back-to-back 10/3 and 20/6 with one idle cycle between -> {1,3} then {2,3}.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM state codes and the
// single-bit protocol levels exchanged with the stall controller and HI/LO path.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic RST_ENABLE       = 1'b1;
  localparam logic STOP             = 1'b1;
  localparam logic NO_STOP          = 1'b0;
  localparam logic RESULT_READY     = 1'b1;
  localparam logic RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START        = 1'b1;
  localparam logic DIV_STOP         = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Holds the pipeline via
// stallreq_o while busy and returns {remainder, quotient} for the HI/LO write.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e         state, state_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic [2*WIDTH:0]   work, work_next;
  logic [WIDTH-1:0]   divisor, divisor_next;
  logic               neg_quot, neg_quot_next;
  logic               neg_rem, neg_rem_next;
  logic [2*WIDTH-1:0] result_next;
  logic               ready_next;

  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH-1:0]   quot, rem;

  // Magnitudes are only taken for signed operations; DIVU uses raw operands.
  assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // One extra bit above the partial remainder so the borrow is unambiguous.
  assign diff = {1'b0, work[2*WIDTH:WIDTH]} - {2'b00, divisor};
  assign quot = work[WIDTH-1:0];
  assign rem  = work[2*WIDTH:WIDTH+1];

  assign stallreq_o = (rst != RST_ENABLE && start_i == DIV_START &&
                       ready_o == RESULT_NOT_READY) ? STOP : NO_STOP;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_next    = state;
    cnt_next      = cnt;
    work_next     = work;
    divisor_next  = divisor;
    neg_quot_next = neg_quot;
    neg_rem_next  = neg_rem;
    result_next   = result_o;
    ready_next    = ready_o;

    unique case (state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = DIV_BYZERO;
          end else begin
            state_next    = DIV_ON;
            cnt_next      = '0;
            divisor_next  = op2_abs;
            work_next     = {{WIDTH{1'b0}}, op1_abs, 1'b0};
            neg_quot_next = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_next  = signed_div_i && opdata1_i[WIDTH-1];
          end
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_next = DIV_FREE;
        end else if (cnt != CW'(WIDTH)) begin
          if (diff[WIDTH+1]) begin
            work_next = {work[2*WIDTH-1:0], 1'b0};
          end else begin
            work_next = {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
          end
          cnt_next = cnt + CW'(1);
        end else begin
          result_next = {neg_rem ? -rem : rem, neg_quot ? -quot : quot};
          ready_next  = RESULT_READY;
          state_next  = DIV_END;
        end
      end

      DIV_BYZERO: begin
        result_next = '0;
        ready_next  = RESULT_READY;
        state_next  = DIV_END;
      end

      DIV_END: begin
        if (start_i == DIV_STOP) begin
          ready_next = RESULT_NOT_READY;
          state_next = DIV_FREE;
        end
      end

      default: state_next = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst == RST_ENABLE) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= RESULT_NOT_READY;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      work     <= work_next;
      divisor  <= divisor_next;
      neg_quot <= neg_quot_next;
      neg_rem  <= neg_rem_next;
      result_o <= result_next;
      ready_o  <= ready_next;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, stall window, signed
// correction, divide-by-zero, annul, mid-operation reset and back-to-back use.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready, stallreq;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a division with start held, count edges and stall cycles until
  // ready, then drop start for one cycle and confirm the result is held.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_result,
                         input int exp_edges);
    int edges = 0;
    int stall_cycles = 0;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    #1;
    while (ready !== 1'b1 && edges < 100) begin
      if (stallreq === 1'b1) stall_cycles++;
      step();
      edges++;
    end
    check({tag, " ready"}, 64'(ready), 64'(1));
    check({tag, " latency"}, 64'(edges), 64'(exp_edges));
    check({tag, " stall_cycles"}, 64'(stall_cycles), 64'(exp_edges));
    check({tag, " result"}, result, exp_result);
    check({tag, " stall_at_ready"}, 64'(stallreq), 64'(0));
    start = 1'b0;
    step();
    check({tag, " ready_drop"}, 64'(ready), 64'(0));
    check({tag, " result_hold"}, result, exp_result);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    annul      = 1'b0;
    signed_div = 1'b0;
    op1        = 32'd5;
    op2        = 32'd1;
    step();
    step();
    check("reset ready", 64'(ready), 64'(0));
    check("reset result", result, 64'(0));
    check("reset stallreq", 64'(stallreq), 64'(0));
    rst   = 1'b0;
    start = 1'b0;
    step();

    run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_div("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            {32'h0000_0000, 32'h8000_0000}, 34);
    run_div("udiv_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
            {32'h8000_0000, 32'h0000_0000}, 34);
    run_div("div_by_zero", 1'b0, 32'd123, 32'd0, 64'(0), 2);

    // annul in FREE must block the start.
    signed_div = 1'b0;
    op1        = 32'd50;
    op2        = 32'd7;
    start      = 1'b1;
    annul      = 1'b1;
    step();
    step();
    step();
    check("annul_free ready", 64'(ready), 64'(0));
    annul = 1'b0;
    run_div("after_annul_free", 1'b0, 32'd50, 32'd7, {32'd1, 32'd7}, 34);

    // annul partway through ON: result discarded, ready never rises.
    op1   = 32'd1000;
    op2   = 32'd9;
    start = 1'b1;
    for (int i = 0; i < 10; i++) step();
    annul = 1'b1;
    step();
    annul = 1'b0;
    start = 1'b0;
    begin
      int ready_seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (ready === 1'b1) ready_seen++;
        step();
      end
      check("annul_on ready_never", 64'(ready_seen), 64'(0));
    end
    check("annul_on result_kept", result, {32'd1, 32'd7});
    run_div("after_annul_on", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Reset partway through ON dominates everything.
    op1   = 32'd1000;
    op2   = 32'd3;
    start = 1'b1;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    check("midop_rst ready", 64'(ready), 64'(0));
    check("midop_rst result", result, 64'(0));
    check("midop_rst stallreq", 64'(stallreq), 64'(0));
    rst   = 1'b0;
    start = 1'b0;
    step();

    run_div("b2b_10_3", 1'b0, 32'd10, 32'd3, {32'd1, 32'd3}, 34);
    run_div("b2b_20_6", 1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
